// File: rtl/prog_loader_if.sv
// Bundle of the host stream, core-side bus, memory-side bus and status lines around prog_loader.
// slave is the loader's view; master is the view of whatever surrounds it.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              programming_enable;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              core_rst;
  logic              core_clk_en;
  logic              memory_WE;
  logic [ADDR_W-1:0] AddressBus;
  logic [DATA_W-1:0] WriteBus;
  logic [DATA_W-1:0] ReadBus;
  logic [DATA_W-1:0] MemReadBus;
  logic [DATA_W-1:0] MemWriteBus;
  logic [ADDR_W-1:0] MemAddressBus;
  logic              MemWE;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  programming_enable, in_data, in_valid,
    input  memory_WE, AddressBus, WriteBus, MemReadBus,
    output in_ready, core_rst, core_clk_en, ReadBus,
    output MemWriteBus, MemAddressBus, MemWE, busy, done, error
  );

  modport master (
    output programming_enable, in_data, in_valid,
    output memory_WE, AddressBus, WriteBus, MemReadBus,
    input  in_ready, core_rst, core_clk_en, ReadBus,
    input  MemWriteBus, MemAddressBus, MemWE, busy, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Framed-stream memory loader that holds the core in reset while writing a program image.
// Optional trailing checksum word is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RST_HOLD = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_in,
  prog_loader_if.slave  io_bus
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR_ADDR = 3'd1,
    ST_HDR_LEN  = 3'd2,
    ST_DATA     = 3'd3,
    ST_FLUSH    = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CSUM     = 3'd6,
`endif
    ST_HOLD     = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_we;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_done;
  logic              r_error;

  logic              w_busy;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_start;
  logic              w_set_done;
  logic              w_set_error;
  logic              w_idle_pass;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_read;
  logic              w_mem_we;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic              w_csum_ok;
`endif

  assign w_busy = (r_state != ST_IDLE);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign w_in_ready = !i_rst_in && io_bus.programming_enable &&
                      ((r_state == ST_HDR_ADDR) || (r_state == ST_HDR_LEN) ||
                       (r_state == ST_DATA) || (r_state == ST_CSUM));
  assign w_csum_ok  = (io_bus.in_data == r_csum);
`else
  assign w_in_ready = !i_rst_in && io_bus.programming_enable &&
                      ((r_state == ST_HDR_ADDR) || (r_state == ST_HDR_LEN) ||
                       (r_state == ST_DATA));
`endif
  assign w_accept = io_bus.in_valid && w_in_ready;
  assign w_start  = (r_state == ST_IDLE) && (w_next == ST_HDR_ADDR);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; dropping programming_enable mid-load aborts into HOLD with error
  always_comb begin
    w_next      = r_state;
    w_set_done  = 1'b0;
    w_set_error = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.programming_enable) w_next = ST_HDR_ADDR;
        else                           w_next = ST_IDLE;
      end
      ST_HDR_ADDR: begin
        if (!io_bus.programming_enable) begin
          w_next      = ST_HOLD;
          w_set_error = 1'b1;
        end else if (w_accept) w_next = ST_HDR_LEN;
        else                   w_next = ST_HDR_ADDR;
      end
      ST_HDR_LEN: begin
        if (!io_bus.programming_enable) begin
          w_next      = ST_HOLD;
          w_set_error = 1'b1;
        end else if (w_accept) w_next = ST_DATA;
        else                   w_next = ST_HDR_LEN;
      end
      ST_DATA: begin
        if (!io_bus.programming_enable) begin
          w_next      = ST_HOLD;
          w_set_error = 1'b1;
        end else if (w_accept && (r_cnt == '0)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          w_next = ST_CSUM;
`else
          w_next = ST_FLUSH;
`endif
        end else w_next = ST_DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (!io_bus.programming_enable) begin
          w_next      = ST_HOLD;
          w_set_error = 1'b1;
        end else if (w_accept) begin
          w_next      = ST_HOLD;
          w_set_done  = w_csum_ok;
          w_set_error = !w_csum_ok;
        end else w_next = ST_CSUM;
      end
`endif
      ST_FLUSH: begin
        w_next = ST_HOLD;
        if (!io_bus.programming_enable) w_set_error = 1'b1;
        else                            w_set_done  = 1'b1;
      end
      ST_HOLD: begin
        if (r_hold_cnt == '0) w_next = ST_IDLE;
        else                  w_next = ST_HOLD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Address pointer, word counter, pending write and status registers
  always_ff @(posedge i_clk) begin
    if (i_rst_in) begin
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_we       <= 1'b0;
      r_hold_cnt <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_we   <= w_accept && (r_state == ST_DATA);
      r_done <= w_set_done;
      if (w_start)          r_error <= 1'b0;
      else if (w_set_error) r_error <= 1'b1;
      if (w_accept) begin
        case (r_state)
          ST_HDR_ADDR: r_ptr <= io_bus.in_data[ADDR_W-1:0];
          ST_HDR_LEN:  r_cnt <= io_bus.in_data;
          ST_DATA: begin
            r_wr_addr <= r_ptr;
            r_wr_data <= io_bus.in_data;
            r_ptr     <= r_ptr + ADDR_W'(1);
            r_cnt     <= r_cnt - DATA_W'(1);
          end
          default: ;
        endcase
      end
      if ((r_state != ST_HOLD) && (w_next == ST_HOLD)) r_hold_cnt <= HOLD_W'(RST_HOLD - 1);
      else if (r_hold_cnt != '0)                       r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running sum of base, length and data words, checked against the trailing word
  always_ff @(posedge i_clk) begin
    if (i_rst_in) begin
      r_csum <= '0;
    end else if (w_accept && (r_state == ST_HDR_ADDR)) begin
      r_csum <= io_bus.in_data;
    end else if (w_accept && ((r_state == ST_HDR_LEN) || (r_state == ST_DATA))) begin
      r_csum <= r_csum + io_bus.in_data;
    end
  end
`endif

  // Idle is a transparent core-to-memory path; otherwise the loader owns the bus
  always_comb begin
    w_idle_pass = (r_state == ST_IDLE) && !i_rst_in;
    if (w_idle_pass) begin
      w_mem_addr  = io_bus.AddressBus;
      w_mem_wdata = io_bus.WriteBus;
      w_mem_we    = io_bus.memory_WE;
      w_read      = io_bus.MemReadBus;
    end else begin
      w_mem_addr  = r_wr_addr;
      w_mem_wdata = r_wr_data;
      w_mem_we    = r_we && !i_rst_in;
      w_read      = '0;
    end
  end

  assign io_bus.in_ready      = w_in_ready;
  assign io_bus.MemAddressBus = w_mem_addr;
  assign io_bus.MemWriteBus   = w_mem_wdata;
  assign io_bus.MemWE         = w_mem_we;
  assign io_bus.ReadBus       = w_read;
  assign io_bus.busy          = w_busy;
  assign io_bus.done          = r_done;
  assign io_bus.error         = r_error;
  assign io_bus.core_rst      = i_rst_in | w_busy;
  assign io_bus.core_clk_en   = ~(i_rst_in | w_busy);

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: framed loads, wrap, abort, bus mux, mid-load reset.
// Checksum scenarios are compiled in when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  logic [7:0] tx_q[$];
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         wc_q[$];
  logic [7:0] mem [256];

  prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  prog_loader #(.ADDR_W(8), .DATA_W(8), .RST_HOLD(2)) dut (
    .i_clk    (clk),
    .i_rst_in (rst),
    .io_bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory and write/done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.MemWE === 1'b1) begin
      mem[bus.MemAddressBus] <= bus.MemWriteBus;
      wa_q.push_back(bus.MemAddressBus);
      wd_q.push_back(bus.MemWriteBus);
      wc_q.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    done_cnt = 0;
  endtask

  // Streams tx_q with in_valid held; stops at done/error, or after abort_after data words with enable dropped
  task automatic drive_frame(input int abort_after, output bit to);
    int  n_acc = 0;
    bit  acc;
    to = 1'b1;
    bus.programming_enable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (abort_after >= 0 && n_acc == abort_after + 2) begin
        bus.programming_enable = 1'b0;
        to = 1'b0;
        break;
      end
      if (n_acc > 0 && (bus.done === 1'b1 || bus.error === 1'b1)) begin
        bus.programming_enable = 1'b0;
        to = 1'b0;
        break;
      end
      bus.in_valid = (tx_q.size() > 0);
      bus.in_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      #1;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        void'(tx_q.pop_front());
        n_acc++;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.busy === 1'b0) begin
        to = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.programming_enable = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h10;
    bus.memory_WE = 1'b1; bus.AddressBus = 8'h33; bus.WriteBus = 8'h5A; bus.MemReadBus = 8'h77;
    repeat (2) step();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.MemWE !== 1'b0) begin n_errors++; $display("FAIL rst_memwe: got %b want 0", bus.MemWE); end
    n_checks++; if (bus.ReadBus !== 8'h00) begin n_errors++; $display("FAIL rst_readbus: got %h want 00", bus.ReadBus); end
    n_checks++; if ({bus.done, bus.error, bus.busy} !== 3'b000) begin n_errors++; $display("FAIL rst_status: got %b want 000", {bus.done, bus.error, bus.busy}); end
    n_checks++; if ({bus.core_rst, bus.core_clk_en} !== 2'b10) begin n_errors++; $display("FAIL rst_core: got %b want 10", {bus.core_rst, bus.core_clk_en}); end
    bus.programming_enable = 1'b0; bus.in_valid = 1'b0; bus.memory_WE = 1'b0;
    rst = 1'b0;
    step();
    n_checks++; if ({bus.core_rst, bus.core_clk_en} !== 2'b01) begin n_errors++; $display("FAIL rst_release_core: got %b want 01", {bus.core_rst, bus.core_clk_en}); end
  endtask

  task automatic test_basic_load();
    bit to;
    logic [7:0] ea [3] = '{8'h10, 8'h11, 8'h12};
    logic [7:0] ed [3] = '{8'hAA, 8'hBB, 8'hCC};
    clear_log();
    tx_q = '{8'h10, 8'h02, 8'hAA, 8'hBB, 8'hCC};
    drive_frame(-1, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL basic_timeout: got %b want 0", to); end
    n_checks++; if (bus.done !== 1'b1) begin n_errors++; $display("FAIL basic_done: got %b want 1", bus.done); end
    n_checks++; if (bus.core_rst !== 1'b1) begin n_errors++; $display("FAIL basic_hold0_rst: got %b want 1", bus.core_rst); end
    bus.in_valid = 1'b1; #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL basic_hold_ready: got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    n_checks++; if (wa_q.size() !== 3) begin n_errors++; $display("FAIL basic_nwrites: got %0d want 3", wa_q.size()); end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      n_checks++; if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin n_errors++; $display("FAIL basic_write%0d: got %h:%h want %h:%h", i, wa_q[i], wd_q[i], ea[i], ed[i]); end
      if (i > 0) begin
        n_checks++; if (wc_q[i] - wc_q[i-1] !== 1) begin n_errors++; $display("FAIL basic_consecutive%0d: got gap %0d want 1", i, wc_q[i] - wc_q[i-1]); end
      end
    end
    step();
    n_checks++; if ({bus.done, bus.core_rst} !== 2'b01) begin n_errors++; $display("FAIL basic_hold1: got %b want 01", {bus.done, bus.core_rst}); end
    step();
    n_checks++; if ({bus.core_rst, bus.core_clk_en, bus.busy} !== 3'b010) begin n_errors++; $display("FAIL basic_release: got %b want 010", {bus.core_rst, bus.core_clk_en, bus.busy}); end
    n_checks++; if (done_cnt !== 1 || bus.error !== 1'b0) begin n_errors++; $display("FAIL basic_done_count: got %0d/%b want 1/0", done_cnt, bus.error); end
  endtask

  task automatic test_wrap();
    bit to;
    logic [7:0] ea [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] ed [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    clear_log();
    tx_q = '{8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
    drive_frame(-1, to);
    n_checks++; if (to !== 1'b0 || bus.done !== 1'b1) begin n_errors++; $display("FAIL wrap_done: got to=%b done=%b want 0/1", to, bus.done); end
    n_checks++; if (wa_q.size() !== 4) begin n_errors++; $display("FAIL wrap_nwrites: got %0d want 4", wa_q.size()); end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      n_checks++; if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin n_errors++; $display("FAIL wrap_write%0d: got %h:%h want %h:%h", i, wa_q[i], wd_q[i], ea[i], ed[i]); end
    end
    wait_idle(to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL wrap_idle_timeout: got %b want 0", to); end
  endtask

  task automatic test_abort();
    bit to;
    clear_log();
    tx_q = '{8'h20, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive_frame(2, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL abort_timeout: got %b want 0", to); end
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL abort_ready: got %b want 0", bus.in_ready); end
    step();
    n_checks++; if ({bus.error, bus.done, bus.busy} !== 3'b101) begin n_errors++; $display("FAIL abort_status: got %b want 101", {bus.error, bus.done, bus.busy}); end
    wait_idle(to);
    n_checks++; if (to !== 1'b0 || bus.core_rst !== 1'b0) begin n_errors++; $display("FAIL abort_release: got to=%b rst=%b want 0/0", to, bus.core_rst); end
    n_checks++; if (bus.error !== 1'b1 || done_cnt !== 0) begin n_errors++; $display("FAIL abort_sticky: got err=%b dones=%0d want 1/0", bus.error, done_cnt); end
    n_checks++; if (wa_q.size() !== 2) begin n_errors++; $display("FAIL abort_nwrites: got %0d want 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      n_checks++; if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== 32'h2011_2122) begin n_errors++; $display("FAIL abort_writes: got %h want 20112122", {wa_q[0], wd_q[0], wa_q[1], wd_q[1]}); end
    end
    tx_q.delete();
  endtask

  task automatic test_passthrough();
    bit to;
    clear_log();
    bus.AddressBus = 8'h33; bus.WriteBus = 8'h5A; bus.memory_WE = 1'b1; bus.MemReadBus = 8'h77;
    #1;
    n_checks++; if ({bus.MemAddressBus, bus.MemWriteBus, bus.MemWE} !== {8'h33, 8'h5A, 1'b1}) begin n_errors++; $display("FAIL pass_mem: got %h %h %b want 33 5a 1", bus.MemAddressBus, bus.MemWriteBus, bus.MemWE); end
    n_checks++; if (bus.ReadBus !== 8'h77) begin n_errors++; $display("FAIL pass_read: got %h want 77", bus.ReadBus); end
    bus.MemReadBus = 8'hC3; #1;
    n_checks++; if (bus.ReadBus !== 8'hC3) begin n_errors++; $display("FAIL pass_read2: got %h want c3", bus.ReadBus); end
    bus.programming_enable = 1'b1;
    step();
    n_checks++; if ({bus.busy, bus.MemWE, bus.in_ready, bus.error} !== 4'b1010) begin n_errors++; $display("FAIL load_bus: got busy/we/rdy/err %b want 1010", {bus.busy, bus.MemWE, bus.in_ready, bus.error}); end
    n_checks++; if (bus.ReadBus !== 8'h00) begin n_errors++; $display("FAIL load_readbus: got %h want 00", bus.ReadBus); end
    bus.programming_enable = 1'b0;
    step();
    bus.memory_WE = 1'b0;
    wait_idle(to);
    n_checks++; if (to !== 1'b0 || bus.error !== 1'b1) begin n_errors++; $display("FAIL pass_abort: got to=%b err=%b want 0/1", to, bus.error); end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_log();
    tx_q = '{8'h40, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
    drive_frame(1, to);
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.MemWE, bus.in_ready, bus.core_rst} !== 3'b001) begin n_errors++; $display("FAIL midrst_now: got we/rdy/rst %b want 001", {bus.MemWE, bus.in_ready, bus.core_rst}); end
    step();
    n_checks++; if ({bus.busy, bus.MemWE, bus.core_rst, bus.core_clk_en} !== 4'b0010) begin n_errors++; $display("FAIL midrst_idle: got %b want 0010", {bus.busy, bus.MemWE, bus.core_rst, bus.core_clk_en}); end
    n_checks++; if ({bus.done, bus.error} !== 2'b00) begin n_errors++; $display("FAIL midrst_status: got %b want 00", {bus.done, bus.error}); end
    step();
    n_checks++; if (bus.core_rst !== 1'b1) begin n_errors++; $display("FAIL midrst_held: got %b want 1", bus.core_rst); end
    rst = 1'b0; #1;
    n_checks++; if (bus.core_rst !== 1'b0 || wa_q.size() !== 0) begin n_errors++; $display("FAIL midrst_release: got rst=%b writes=%0d want 0/0", bus.core_rst, wa_q.size()); end
    step();
    clear_log();
    tx_q = '{8'h80, 8'h00, 8'h99};
    drive_frame(-1, to);
    n_checks++; if (to !== 1'b0 || bus.done !== 1'b1) begin n_errors++; $display("FAIL midrst_reload: got to=%b done=%b want 0/1", to, bus.done); end
    n_checks++; if (wa_q.size() !== 1 || mem[8'h80] !== 8'h99) begin n_errors++; $display("FAIL midrst_reload_write: got n=%0d mem=%h want 1/99", wa_q.size(), mem[8'h80]); end
    wait_idle(to);
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit to;
    clear_log();
    tx_q = '{8'h00, 8'h00, 8'h05, 8'h05};
    drive_frame(-1, to);
    n_checks++; if ({to, bus.done, bus.error} !== 3'b010) begin n_errors++; $display("FAIL csum_ok: got to/done/err %b want 010", {to, bus.done, bus.error}); end
    n_checks++; if (mem[8'h00] !== 8'h05) begin n_errors++; $display("FAIL csum_ok_mem: got %h want 05", mem[8'h00]); end
    wait_idle(to);
    clear_log();
    mem[8'h00] = 8'h00;
    tx_q = '{8'h00, 8'h00, 8'h05, 8'h06};
    drive_frame(-1, to);
    n_checks++; if ({to, bus.done, bus.error} !== 3'b001) begin n_errors++; $display("FAIL csum_bad: got to/done/err %b want 001", {to, bus.done, bus.error}); end
    wait_idle(to);
    n_checks++; if (done_cnt !== 0 || mem[8'h00] !== 8'h05) begin n_errors++; $display("FAIL csum_bad_mem: got dones=%0d mem=%h want 0/05", done_cnt, mem[8'h00]); end
  endtask
`endif

  initial begin
    bus.programming_enable = 1'b0; bus.in_data = 8'h00; bus.in_valid = 1'b0;
    bus.memory_WE = 1'b0; bus.AddressBus = 8'h00; bus.WriteBus = 8'h00; bus.MemReadBus = 8'h00;
    test_reset();
    test_basic_load();
    test_wrap();
    test_abort();
    test_passthrough();
    test_reset_mid();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Parametrised successor of the memory programming mux.
- Accepts a framed word stream (valid/ready) from a host link such as a UART receiver.
- Writes the payload into the shared instruction/data memory at an auto-incrementing address, holding the core in reset with its clock enable low for the whole load.
- When idle, it is a transparent path between the core's memory bus and the memory.

Parameters:
ADDR_W, 8, memory address width; must satisfy ADDR_W <= DATA_W
DATA_W, 8, memory word and stream word width
RST_HOLD, 2, cycles core_rst stays high after a successful load

Ports:
clk  in  1  system clock; the only clock
rst_in  in  1  synchronous, active-high reset
programming_enable  in  1  level request: high starts a load and keeps it alive
in_data  in  DATA_W  stream word
in_valid  in  1  stream word valid
in_ready  out  1  loader accepts in_data this cycle
core_rst  out  1  reset to core
core_clk_en  out  1  clock enable to core (no clock gating)
memory_WE  in  1  core write enable
AddressBus  in  ADDR_W  core address
WriteBus  in  DATA_W  core write data
ReadBus  out  DATA_W  core read data
MemReadBus  in  DATA_W  memory read data
MemWriteBus  out  DATA_W  memory write data
MemAddressBus  out  ADDR_W  memory address
MemWE  out  1  memory write enable
busy  out  1  load in progress (any state except IDLE)
done  out  1  one-cycle pulse when a load completes successfully
error  out  1  sticky; cleared by rst_in or by the next load start

Behaviour:
- Reset is synchronous, active-high. On rst_in: state=IDLE; in_ready=0, MemWE=0, done=0, error=0, busy=0; core_rst=1, core_clk_en=0.
- Frame format, one word per handshake:
  - word 0: base address; the low ADDR_W bits are used.
  - word 1: length L; the loader writes L+1 data words, so 1 to 2^DATA_W words.
  - then the data words.
- A word is accepted in any cycle where in_valid && in_ready.
- States:
  - IDLE -> HDR_ADDR when programming_enable=1.
  - HDR_ADDR -> HDR_LEN on accept.
  - HDR_LEN -> DATA on accept.
  - DATA -> FLUSH on accepting the last word.
  - FLUSH -> HOLD after the final write is issued.
  - HOLD -> IDLE after RST_HOLD cycles.
- in_ready=1 only in HDR_ADDR, HDR_LEN and DATA. It is also 1 on the same cycle as a pending write, so there are no bubbles: one word per cycle.
- Write timing:
  - A data word accepted in cycle N gives MemWE=1 in cycle N+1, with MemAddressBus=ptr and MemWriteBus=word. Both come from registers.
  - ptr then increments, modulo 2^ADDR_W; wrap from all-ones to 0 is legal and silent.
- done pulses on the first cycle of HOLD.
- Core control:
  - core_rst = rst_in | busy, where busy covers HDR_ADDR through HOLD.
  - core_clk_en = ~core_rst.
- Bus mux:
  - While busy, MemAddressBus, MemWriteBus and MemWE come from the loader registers; MemWE=0 except on write cycles.
  - While busy, ReadBus=0 and the core's memory_WE is ignored.
  - In IDLE (and not in rst_in), the memory bus is passed through combinationally: MemAddressBus=AddressBus, MemWriteBus=WriteBus, MemWE=memory_WE, ReadBus=MemReadBus.
- Abort: programming_enable=0 in any state from HDR_ADDR to FLUSH.
  - error=1 next cycle, no done pulse, state -> HOLD.
  - A write issued in that abort cycle still completes; no further writes follow.
- programming_enable still high on return to IDLE starts a new load immediately. programming_enable is not sampled in HOLD.
- in_valid in IDLE or HOLD is not accepted (in_ready=0); the word is left for the source.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last data word the loader enters state CSUM (in_ready=1) and accepts one checksum word.
  - The expected checksum is the sum modulo 2^DATA_W of the base address, L and all data words. A matching checksum word -> HOLD with done pulse.
  - Mismatch -> HOLD with error=1 and no done. Memory is already written; no rollback.
  - FLUSH runs in parallel with CSUM.
- Disabled: no CSUM state, no checksum accumulator; DATA -> FLUSH directly.

Test Plan:
- Load base 0x10, L=2, data 0xAA,0xBB,0xCC with in_valid held high -> MemWE pulses at addresses 0x10,0x11,0x12 with that data on consecutive cycles; done pulses once; core_rst stays high for RST_HOLD cycles, then 0.
- Base 0xFE, L=3, data 1,2,3,4 -> writes to 0xFE,0xFF,0x00,0x01 (wrap-around).
- Deassert programming_enable after the 2nd data word of L=4 -> exactly 2 writes, error=1, done=0; core released after RST_HOLD.
- In IDLE, core drives AddressBus=0x33, WriteBus=0x5A, memory_WE=1 -> same values on the Mem* ports the same cycle. During a load, the core's memory_WE=1 -> no effect, ReadBus=0.
- Assert rst_in mid-DATA -> next cycle IDLE, MemWE=0, core_rst=1 while rst_in is held; a fresh load afterwards succeeds.
- With PROG_LOADER_CHECKSUM_EN: base 0x00, L=0, data 0x05, checksum 0x05 -> done=1. Same frame with checksum 0x06 -> error=1, no done, memory[0]=0x05.
